divu_iter: RTL and testbench

Iterative radix-2 unsigned divider for the 54-instruction MIPS core. It executes DIVU, the inverse of the pipelined MULTU: quotient goes to LO and remainder goes to HI. It sits beside the multiplier in the HI/LO unit and uses the same start/done convention, so the CPU stall logic treats both units identically. It uses one restoring-division step per cycle, with a shared subtractor and no pipeline.

---
 rtl/divu_pkg.sv | 10 +
 rtl/divu_step.sv | 24 ++
 rtl/divu_iter.sv | 111 +++++++++++
 tb/tb_divu_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared types and sizing for the iterative unsigned divider (divu_iter).
package divu_pkg;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } divu_state_e;

  localparam int DIVU_WIDTH = 32;
  localparam int DIVU_CNT_W = $clog2(DIVU_WIDTH);
endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor, keep the difference if it did not borrow.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_wq,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_wq
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  // The working remainder stays below the divisor, so its top bit is zero and
  // this behaves as the (WIDTH+1)-bit trial subtract.
  assign w_shift = {i_rem, i_wq[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, i_dvs};
  assign w_neg   = w_diff[WIDTH+1];

  assign o_rem = w_neg ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
  assign o_wq  = {i_wq[WIDTH-2:0], ~w_neg};
endmodule

// File: rtl/divu_iter.sv
// Iterative radix-2 restoring DIVU unit (q -> LO, r -> HI), falling-edge clocked.
// Optional build macro DIVU_ZERO_FAST_EN: zero divisor completes on the load edge.
module divu_iter
  import divu_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output divu_state_e      o_state
);
  localparam int CNT_W = $clog2(WIDTH);

  divu_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_wq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_wq_nxt;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_wq  (r_wq),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_wq  (w_wq_nxt)
  );

  // Handshake: start is sampled only in IDLE; done is a level that is high
  // exactly when no operation is in flight and q/r/dz hold the last result.
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_wq    <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
`ifdef DIVU_ZERO_FAST_EN
            if (i_b == '0) begin
              r_q  <= '1;
              r_r  <= i_a;
              r_dz <= 1'b1;
            end else begin
              r_wq    <= i_a;
              r_dvs   <= i_b;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_state <= S_RUN;
            end
`else
            r_wq    <= i_a;
            r_dvs   <= i_b;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_wq  <= w_wq_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_q     <= w_wq_nxt;
            r_r     <= w_rem_nxt[WIDTH-1:0];
            r_dz    <= (r_dvs == '0);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_q     = r_q;
  assign o_r     = r_r;
  assign o_dz    = r_dz;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_state = r_state;
endmodule

// File: tb/tb_divu_iter.sv
// Bench for divu_iter: directed literal cases plus random traffic against an
// arithmetic reference (a/b, a%b, fixed latency), compared every rising edge.
module tb_divu_iter;
  import divu_pkg::*;

  localparam int WIDTH = DIVU_WIDTH;
`ifdef DIVU_ZERO_FAST_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = WIDTH;
`endif

  logic             clk;
  logic             i_reset;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_r;
  logic             o_busy;
  logic             o_done;
  logic             o_dz;
  divu_state_e      o_state;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  divu_iter #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_q     (o_q),
    .o_r     (o_r),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_dz    (o_dz),
    .o_state (o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: an accepted request finishes WIDTH falling edges later with the
  // arithmetic quotient/remainder; outputs hold their old values meanwhile.
  logic             m_busy = 1'b0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic             m_dz = 1'b0, p_dz = 1'b0;

  always @(negedge clk) begin
    if (i_reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
    end else if (!m_busy) begin
      if (i_start) begin
        if (i_b == '0 && ZERO_LAT == 0) begin
          m_q  <= '1;
          m_r  <= i_a;
          m_dz <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_left <= WIDTH;
          p_q    <= (i_b == '0) ? '1 : i_a / i_b;
          p_r    <= (i_b == '0) ? i_a : i_a % i_b;
          p_dz   <= (i_b == '0);
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_q    <= p_q;
        m_r    <= p_r;
        m_dz   <= p_dz;
      end
    end
  end

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard compare, every rising edge (DUT moves on falling edges)
  always @(posedge clk) begin
    if (chk_en) begin
      check("sb_busy", WIDTH'(o_busy), WIDTH'(m_busy));
      check("sb_done", WIDTH'(o_done), WIDTH'(!m_busy));
      check("sb_state", WIDTH'(o_state), WIDTH'(m_busy ? S_RUN : S_IDLE));
      check("sb_q", o_q, m_q);
      check("sb_r", o_r, m_r);
      check("sb_dz", WIDTH'(o_dz), WIDTH'(m_dz));
    end
  end

  // driver tasks
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (!o_done) begin
      n_errors++;
      $display("FAIL %s: timeout waiting for done, got 0 expected 1", nm);
    end
  endtask

  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
    wait_idle("pre_idle");
    @(posedge clk);
    launch(a, b);
    lat = 0;
    while (!o_done && lat < 200) begin
      lat++;
      @(posedge clk);
    end
    if (!o_done) begin
      n_errors++;
      $display("FAIL run_op: timeout, done got 0 expected 1");
    end
  endtask

  initial begin
    int lat;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge clk);
    i_reset = 1'b0;
    chk_en  = 1'b1;
    check("rst_q", o_q, 0);
    check("rst_r", o_r, 0);
    check("rst_done", WIDTH'(o_done), 1);
    check("rst_busy", WIDTH'(o_busy), 0);
    check("rst_dz", WIDTH'(o_dz), 0);

    run_op(100, 7, lat);
    check("lat_100_7", lat, WIDTH);
    check("q_100_7", o_q, 14);
    check("r_100_7", o_r, 2);
    check("dz_100_7", WIDTH'(o_dz), 0);

    run_op('1, 1, lat);
    check("q_max_1", o_q, 32'hFFFF_FFFF);
    check("r_max_1", o_r, 0);
    run_op('1, '1, lat);
    check("q_max_max", o_q, 1);
    check("r_max_max", o_r, 0);
    run_op(5, 9, lat);
    check("q_5_9", o_q, 0);
    check("r_5_9", o_r, 5);
    run_op(0, 3, lat);
    check("q_0_3", o_q, 0);
    check("r_0_3", o_r, 0);

    run_op(1234, 0, lat);
    check("lat_div0", lat, ZERO_LAT);
    check("q_div0", o_q, 32'hFFFF_FFFF);
    check("r_div0", o_r, 1234);
    check("dz_div0", WIDTH'(o_dz), 1);

    // start while busy must be ignored; old result held during RUN
    wait_idle("pre_ignore");
    @(posedge clk);
    launch(100, 7);
    repeat (9) @(posedge clk);
    launch(50, 5);
    check("hold_q", o_q, 32'hFFFF_FFFF);
    check("hold_r", o_r, 1234);
    check("hold_busy", WIDTH'(o_busy), 1);
    wait_idle("ignore");
    check("q_ignore", o_q, 14);
    check("r_ignore", o_r, 2);
    check("dz_ignore", WIDTH'(o_dz), 0);

    // reset mid-run aborts with reset values
    @(posedge clk);
    launch(100, 7);
    repeat (14) @(posedge clk);
    i_reset = 1'b1;
    @(posedge clk);
    i_reset = 1'b0;
    check("abort_q", o_q, 0);
    check("abort_r", o_r, 0);
    check("abort_busy", WIDTH'(o_busy), 0);
    check("abort_done", WIDTH'(o_done), 1);
    run_op(9, 3, lat);
    check("lat_9_3", lat, WIDTH);
    check("q_9_3", o_q, 3);
    check("r_9_3", o_r, 0);

    // random traffic, including start held across completion and rare resets
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      i_start = ($urandom_range(0, 2) == 0);
      i_a     = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 200)) : WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0:       i_b = '0;
        1:       i_b = WIDTH'($urandom_range(1, 15));
        2:       i_b = '1;
        3:       i_b = WIDTH'($urandom) >> $urandom_range(0, 31);
        default: i_b = WIDTH'($urandom);
      endcase
      i_reset = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk);
    i_start = 1'b0;
    i_reset = 1'b0;
    wait_idle("final");
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
